// File: rtl/apb_master_if.sv
// Bundles the request/response handshake and the APB bus seen by apb_master.
// The master modport is the DUT view; the slave modport is the environment view.
interface apb_master_if;
   // A request transfers on any rising edge where req_valid && req_ready.
   // rsp_valid is a single-cycle pulse; rsp_rdata/rsp_err are valid with it.
   logic       req_valid;
   logic       req_write;
   logic [8:0] req_addr;
   logic [7:0] req_wdata;
   logic       req_ready;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       PSEL1;
   logic       PSEL2;
   logic       PENABLE;
   logic       PWRITE;
   logic [7:0] padd;
   logic [7:0] pwdata;
   logic       PREADY;
   logic [7:0] prdata1;
   logic [7:0] prdata2;
   logic [1:0] state_dbg;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, PREADY, prdata1, prdata2,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL1, PSEL2, PENABLE,
             PWRITE, padd, pwdata, state_dbg
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, PREADY, prdata1, prdata2,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL1, PSEL2, PENABLE,
             PWRITE, padd, pwdata, state_dbg
   );
endinterface

// File: rtl/apb_master.sv
// Two-slave APB master: one outstanding transfer, back-to-back capable.
// Optional ACCESS-phase timeout abort is built with APB_MASTER_TIMEOUT_EN.
module apb_master #(
   parameter int TMO_CYC = 16
) (
   input  logic          PCLK,
   input  logic          PRST,
   apb_master_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   sel2;
   logic   req_ready;
   logic   accept;
   logic   done;
   logic   tmo;

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      case (state)
         IDLE:    req_ready = 1'b1;
         ACCESS:  req_ready = bus.PREADY;
         default: req_ready = 1'b0;
      endcase
      accept = bus.req_valid && req_ready;
      done   = (state == ACCESS) && (bus.PREADY || tmo);
      case (state)
         IDLE:    if (accept) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS: begin
            if (bus.PREADY)   state_nxt = accept ? SETUP : IDLE;
            else if (tmo)     state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRST) begin
         state         <= IDLE;
         sel2          <= 1'b0;
         bus.PWRITE    <= 1'b0;
         bus.padd      <= 8'h00;
         bus.pwdata    <= 8'h00;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= 8'h00;
      end else begin
         state         <= state_nxt;
         bus.rsp_valid <= done;
         if (accept) begin
            bus.PWRITE <= bus.req_write;
            bus.padd   <= bus.req_addr[7:0];
            bus.pwdata <= bus.req_wdata;
            sel2       <= bus.req_addr[8];
         end
         // Writes and aborted transfers report zero read data.
         if (done)
            bus.rsp_rdata <= (tmo || bus.PWRITE) ? 8'h00 : (sel2 ? bus.prdata2 : bus.prdata1);
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.PSEL1     = (state != IDLE) && !sel2;
   assign bus.PSEL2     = (state != IDLE) && sel2;
   assign bus.PENABLE   = (state == ACCESS);
   assign bus.state_dbg = state;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TMO_CYC + 1);
   logic [CNT_W-1:0] wait_cnt;

   // wait_cnt holds the wait cycles already spent; this cycle is the TMO_CYC-th.
   assign tmo = (state == ACCESS) && !bus.PREADY && (wait_cnt == CNT_W'(TMO_CYC - 1));

   always_ff @(posedge PCLK) begin
      if (!PRST) begin
         wait_cnt    <= '0;
         bus.rsp_err <= 1'b0;
      end else begin
         bus.rsp_err <= tmo;
         if (state_nxt == SETUP || state != ACCESS)
            wait_cnt <= '0;
         else if (!bus.PREADY)
            wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end
`else
   logic unused_tmo_cyc;
   assign unused_tmo_cyc = (TMO_CYC != 0);
   assign tmo            = 1'b0;
   assign bus.rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: memory-backed slave model, request driver,
// and a monitor that scores responses and APB bus activity against queues.
module tb_apb_master;
   localparam int TMO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic PCLK = 1'b0;
   logic PRST = 1'b0;

   apb_master_if bus ();

   apb_master #(.TMO_CYC(TMO)) dut (
      .PCLK (PCLK),
      .PRST (PRST),
      .bus  (bus)
   );

   always #5 PCLK = ~PCLK;

   int total = 0;
   int bad   = 0;

   logic [8:0]  exp_q[$];   // {err, rdata}
   logic [17:0] bus_q[$];   // {sel2, write, addr, wdata}
   int          wait_q[$];

   logic [7:0] ref_mem [2][256];
   logic [7:0] slv_mem [2][256];

   int         wait_left = 0;
   int         run1 = 0, run2 = 0, runp = 0;
   int         last_psel1 = 0, last_psel2 = 0, last_pen = 0;
   logic [7:0] last_rdata = 8'h00;
   bit         prev_setup = 1'b0;
   logic [8:0] mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input int act, input int exp);
      total++;
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Slave: N wait cycles per transfer, then PREADY; writes land in slv_mem.
   always @(negedge PCLK) begin
      if (!PRST) begin
         bus.PREADY = 1'b0;
         wait_left  = 0;
      end else if ((bus.PSEL1 || bus.PSEL2) && !bus.PENABLE) begin
         wait_left  = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
         bus.PREADY = 1'b0;
      end else if (bus.PSEL1 || bus.PSEL2) begin
         if (wait_left == 0) begin
            bus.PREADY = 1'b1;
            if (bus.PWRITE) slv_mem[bus.PSEL2][bus.padd] = bus.pwdata;
         end else begin
            bus.PREADY = 1'b0;
            wait_left--;
         end
      end else begin
         bus.PREADY = 1'($urandom_range(0, 1));
      end
      bus.prdata1 = slv_mem[0][bus.padd];
      bus.prdata2 = slv_mem[1][bus.padd];
   end

   // Monitor: responses, bus fields of the transfer in flight, phase ordering.
   always @(negedge PCLK) begin
      if (!PRST) begin
         last_rdata = 8'h00;
         prev_setup = 1'b0;
         run1 = 0; run2 = 0; runp = 0;
      end else begin
         if (bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
               fail("unexpected_rsp", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               check("rsp", 32'({bus.rsp_err, bus.rsp_rdata}), 32'(mon_e));
            end
            if (bus_q.size() > 0) void'(bus_q.pop_front());
            last_rdata = bus.rsp_rdata;
         end else begin
            check("rdata_hold", 32'(bus.rsp_rdata), 32'(last_rdata));
         end
         check("psel_onehot", 32'(bus.PSEL1 & bus.PSEL2), 32'(0));
         if (prev_setup) check("setup_to_access", 32'(bus.PENABLE), 32'(1));
         if (bus.PSEL1 || bus.PSEL2) begin
            if (bus_q.size() == 0) fail("spurious_psel", 1, 0);
            else check("bus_fields", 32'({bus.PSEL2, bus.PWRITE, bus.padd, bus.pwdata}), 32'(bus_q[0]));
         end else begin
            check("penable_idle", 32'(bus.PENABLE), 32'(0));
         end
         prev_setup = (bus.PSEL1 || bus.PSEL2) && !bus.PENABLE;
         if (bus.PSEL1) run1++; else if (run1 > 0) begin last_psel1 = run1; run1 = 0; end
         if (bus.PSEL2) run2++; else if (run2 > 0) begin last_psel2 = run2; run2 = 0; end
         if (bus.PENABLE) runp++; else if (runp > 0) begin last_pen = runp; runp = 0; end
      end
   end

   // Holds req_valid until accepted; leaves it asserted on return (posedge + 1).
   task automatic send(input logic w, input logic [8:0] a, input logic [7:0] d,
                       input int n, output int cyc);
      bit         acc;
      bit         tmo_hit;
      logic [8:0] e;
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      cyc = 0;
      acc = 1'b0;
      while (!acc && cyc < 400) begin
         @(negedge PCLK);
         #1;
         acc = bus.req_ready;
         @(posedge PCLK);
         cyc++;
      end
      if (!acc) begin
         fail("accept_timeout", cyc, 400);
         bus.req_valid = 1'b0;
      end else begin
         tmo_hit = TMO_EN && (n >= TMO);
         if (tmo_hit)  e = 9'h100;
         else if (w)   e = 9'h000;
         else          e = {1'b0, ref_mem[a[8]][a[7:0]]};
         if (w && !tmo_hit) ref_mem[a[8]][a[7:0]] = d;
         exp_q.push_back(e);
         bus_q.push_back({a[8], w, a[7:0], d});
         wait_q.push_back(n);
      end
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_psel1"},   32'(bus.PSEL1),     32'(0));
      check({tag, "_psel2"},   32'(bus.PSEL2),     32'(0));
      check({tag, "_penable"}, 32'(bus.PENABLE),   32'(0));
      check({tag, "_pwrite"},  32'(bus.PWRITE),    32'(0));
      check({tag, "_padd"},    32'(bus.padd),      32'(0));
      check({tag, "_pwdata"},  32'(bus.pwdata),    32'(0));
      check({tag, "_rsp_vld"}, 32'(bus.rsp_valid), 32'(0));
      check({tag, "_rdata"},   32'(bus.rsp_rdata), 32'(0));
      check({tag, "_rsp_err"}, 32'(bus.rsp_err),   32'(0));
      check({tag, "_state"},   32'(bus.state_dbg), 32'(0));
      check({tag, "_ready"},   32'(bus.req_ready), 32'(1));
   endtask

   initial begin
      int         c;
      int         gap;
      int         k;
      logic [7:0] v;
      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 256; a++) begin
            v = 8'($urandom);
            ref_mem[s][a] = v;
            slv_mem[s][a] = v;
         end
      end
      ref_mem[1][8'h12] = 8'h77;
      slv_mem[1][8'h12] = 8'h77;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = 9'h000;
      bus.req_wdata = 8'h00;
      bus.PREADY    = 1'b0;
      bus.prdata1   = 8'h00;
      bus.prdata2   = 8'h00;

      // Reset state
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      check_reset_outputs("reset");
      @(posedge PCLK);
      #1 PRST = 1'b1;

      // Write 0x0A5 <- 0x3C, no wait states
      send(1'b1, 9'h0A5, 8'h3C, 0, c);
      bus.req_valid = 1'b0;
      repeat (4) @(negedge PCLK);
      check("wr_psel1_len", 32'(last_psel1), 32'(2));
      check("wr_pen_len",   32'(last_pen),   32'(1));
      check("wr_psel2_len", 32'(last_psel2), 32'(0));

      // Read 0x112 with 3 wait cycles
      @(posedge PCLK);
      #1;
      send(1'b0, 9'h112, 8'h00, 3, c);
      bus.req_valid = 1'b0;
      repeat (8) @(negedge PCLK);
      check("rd_psel2_len", 32'(last_psel2), 32'(5));
      check("rd_psel1_len", 32'(last_psel1), 32'(2));

      // Back-to-back reads on slave 1 with req_valid held
      @(posedge PCLK);
      #1;
      send(1'b0, 9'h003, 8'h00, 1, c);
      send(1'b0, 9'h004, 8'h00, 2, c);
      check("b2b_accept_cyc", 32'(c), 32'(3));
      bus.req_valid = 1'b0;
      repeat (8) @(negedge PCLK);
      check("b2b_psel1_len", 32'(last_psel1), 32'(7));

      // Reset while in ACCESS, then a normal transfer
      @(posedge PCLK);
      #1;
      send(1'b0, 9'h034, 8'h00, 5, c);
      bus.req_valid = 1'b0;
      @(posedge PCLK);
      #1 PRST = 1'b0;
      @(posedge PCLK);
      @(negedge PCLK);
      check_reset_outputs("abort");
      exp_q.delete();
      bus_q.delete();
      wait_q.delete();
      @(posedge PCLK);
      #1 PRST = 1'b1;
      send(1'b0, 9'h034, 8'h00, 1, c);
      bus.req_valid = 1'b0;

      // Long stall: aborted only when the timeout is built in
      send(1'b0, 9'h020, 8'h00, 120, c);
      bus.req_valid = 1'b0;
      repeat (100) @(negedge PCLK);
      check("stall_psel", 32'(bus.PSEL1 | bus.PSEL2), 32'(!TMO_EN));
      @(posedge PCLK);
      #1;

      // Random traffic on a small address window so reads hit earlier writes
      for (int i = 0; i < 60; i++) begin
         send(1'($urandom_range(0, 1)),
              {1'($urandom_range(0, 1)), 8'($urandom_range(0, 15))},
              8'($urandom), $urandom_range(0, 6), c);
         gap = $urandom_range(0, 2);
         if (gap > 0) begin
            bus.req_valid = 1'b0;
            repeat (gap) @(posedge PCLK);
            #1;
         end
      end
      bus.req_valid = 1'b0;

      k = 0;
      while (exp_q.size() > 0 && k < 1000) begin
         @(negedge PCLK);
         k++;
      end
      check("drain", 32'(exp_q.size()), 32'(0));
      repeat (2) @(negedge PCLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
